// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer.
// Holds branch-type codes and the weakly-taken counter reset value.
package branch_target_buffer_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  localparam logic [1:0] BTB_CTR_WT = 2'b10;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Pipeline <-> BTB bundle: IF lookup, EX training/mispredict, stats.
// master = pipeline side, slave = BTB side.
interface branch_target_buffer_if
  import branch_target_buffer_pkg::*;
#(
  parameter int STAT_W = 32
) ();

  logic [31:0]       PCF;
  logic              PredTakenF;
  logic [31:0]       PredTargetF;
  logic [31:0]       PCE;
  br_type_e          BranchTypeE;
  logic              BranchE;
  logic [31:0]       BrTargetE;
  logic              PredTakenE;
  logic [31:0]       PredTargetE;
  logic              StallE;
  logic              MispredictE;
  logic [31:0]       CorrectPCE;
  logic [STAT_W-1:0] BrCount;
  logic [STAT_W-1:0] MissCount;

  modport master (
    output PCF, PCE, BranchTypeE, BranchE,
    output BrTargetE, PredTakenE, PredTargetE,
    output StallE,
    input  PredTakenF, PredTargetF,
    input  MispredictE, CorrectPCE,
    input  BrCount, MissCount
  );

  modport slave (
    input  PCF, PCE, BranchTypeE, BranchE,
    input  BrTargetE, PredTakenE, PredTargetE,
    input  StallE,
    output PredTakenF, PredTargetF,
    output MispredictE, CorrectPCE,
    output BrCount, MissCount
  );

endinterface

// File: rtl/branch_target_buffer_sat_ctr.sv
// 2-bit saturating counter next-state function.
// Ports: ctr (current), taken (outcome) -> nxt (next value).
module btb_sat_ctr (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters; IF lookup, EX training.
// Ports: clk, rst_n (async low), bus (slave modport of the BTB bundle).
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = BTB_CTR_WT,
  parameter int         STAT_W   = 32
) (
  input logic clk,
  input logic rst_n,
  branch_target_buffer_if.slave bus
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             v_q   [N];
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       ctr_q [N];

  logic [STAT_W-1:0] br_q;
  logic [STAT_W-1:0] miss_q;

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic             taken_f;

  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             is_br;
  logic             tgt_bad;
  logic             mis;
  logic             train;
  logic [1:0]       ctr_nxt;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.PCF[1:0], bus.PCE[1:0]};

  assign idx_f   = bus.PCF[IDX_W+1:2];
  assign tag_f   = bus.PCF[31:IDX_W+2];
  assign hit_f   = v_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign taken_f = hit_f && ctr_q[idx_f][1];

  assign bus.PredTakenF  = taken_f;
  assign bus.PredTargetF = taken_f ? tgt_q[idx_f]
                                   : bus.PCF + 32'd4;

  assign idx_e = bus.PCE[IDX_W+1:2];
  assign tag_e = bus.PCE[31:IDX_W+2];
  assign hit_e = v_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign is_br = bus.BranchTypeE != NOBRANCH;

  assign tgt_bad = bus.PredTakenE && bus.BranchE &&
                   (bus.PredTargetE != bus.BrTargetE);

  // Qualified by rst_n so no flush is requested while in reset.
  assign mis = rst_n && is_br &&
               ((bus.PredTakenE != bus.BranchE) || tgt_bad);

  assign bus.MispredictE = mis;
  assign bus.CorrectPCE  = bus.BranchE ? bus.BrTargetE
                                       : bus.PCE + 32'd4;

  assign train = is_br && !bus.StallE;

  btb_sat_ctr u_ctr (
    .ctr   (ctr_q[idx_e]),
    .taken (bus.BranchE),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_INIT;
      end
    end else if (train) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_nxt;
        if (bus.BranchE) tgt_q[idx_e] <= bus.BrTargetE;
      end else if (bus.BranchE) begin
        v_q[idx_e]   <= 1'b1;
        tag_q[idx_e] <= tag_e;
        tgt_q[idx_e] <= bus.BrTargetE;
        ctr_q[idx_e] <= CTR_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (train) begin
      if (br_q != '1) br_q <= br_q + 1'b1;
      if (mis && (miss_q != '1)) miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.BrCount   = br_q;
  assign bus.MissCount = miss_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer.
// Uses 4-bit stats so saturation can be reached quickly.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  localparam int SW = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  branch_target_buffer_if #(.STAT_W(SW)) bus ();

  branch_target_buffer #(
    .IDX_W    (6),
    .CTR_INIT (2'b10),
    .STAT_W   (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input br_type_e t,
                    input logic [31:0] pce,
                    input logic br,
                    input logic [31:0] tgt,
                    input logic pt,
                    input logic [31:0] ptgt);
    bus.BranchTypeE = t;
    bus.PCE         = pce;
    bus.BranchE     = br;
    bus.BrTargetE   = tgt;
    bus.PredTakenE  = pt;
    bus.PredTargetE = ptgt;
    #1;
  endtask

  task automatic idle();
    bus.BranchTypeE = NOBRANCH;
    bus.BranchE     = 1'b0;
    bus.PredTakenE  = 1'b0;
    #1;
  endtask

  task automatic look(input string tag,
                      input logic [31:0] pc,
                      input logic t,
                      input logic [31:0] tgt);
    bus.PCF = pc;
    #1;
    chk({tag, "_tk"}, 32'(bus.PredTakenF), 32'(t));
    chk({tag, "_tg"}, bus.PredTargetF, tgt);
  endtask

  task automatic cnt(input string tag,
                     input int b,
                     input int m);
    chk({tag, "_br"}, 32'(bus.BrCount), 32'(b));
    chk({tag, "_ms"}, 32'(bus.MissCount), 32'(m));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.PCF     = 32'h40;
    bus.StallE  = 1'b0;
    ex(BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);

    look("rst", 32'h40, 1'b0, 32'h44);
    chk("rst_mis", 32'(bus.MispredictE), 32'd0);
    cnt("rst", 0, 0);
    idle();
    #20;
    rst_n = 1'b1;
    tick();

    // First taken branch: miss, allocate.
    ex(BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    chk("alloc_mis", 32'(bus.MispredictE), 32'd1);
    chk("alloc_cpc", bus.CorrectPCE, 32'h80);
    look("alloc_pre", 32'h40, 1'b0, 32'h44);
    tick();
    idle();
    look("alloc_post", 32'h40, 1'b1, 32'h80);
    cnt("alloc", 1, 1);

    // Three more taken, correctly predicted: ctr 3.
    for (int i = 0; i < 3; i++) begin
      ex(BEQ, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      chk("tk_mis", 32'(bus.MispredictE), 32'd0);
      tick();
    end
    idle();
    cnt("tk", 4, 1);

    // Two not-taken with taken predicted: ctr 3->2->1.
    ex(BEQ, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    chk("nt1_mis", 32'(bus.MispredictE), 32'd1);
    chk("nt1_cpc", bus.CorrectPCE, 32'h44);
    tick();
    idle();
    look("nt1", 32'h40, 1'b1, 32'h80);
    ex(BEQ, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    chk("nt2_mis", 32'(bus.MispredictE), 32'd1);
    tick();
    idle();
    look("nt2", 32'h40, 1'b0, 32'h44);
    cnt("nt", 6, 3);

    // Entry still valid: 1->0, then taken 0->1 stays not-taken.
    ex(BEQ, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    chk("nt3_mis", 32'(bus.MispredictE), 32'd0);
    tick();
    ex(BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    tick();
    idle();
    look("valid", 32'h40, 1'b0, 32'h44);
    cnt("valid", 8, 4);

    // Aliasing: 0x140 shares index with 0x40.
    ex(BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    tick();
    idle();
    look("al_pre", 32'h40, 1'b1, 32'h80);
    ex(BNE, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    tick();
    idle();
    look("al_old", 32'h40, 1'b0, 32'h44);
    look("al_new", 32'h140, 1'b1, 32'h200);
    cnt("al", 10, 6);

    // Target change on a hit.
    ex(BLT, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    chk("tc_mis", 32'(bus.MispredictE), 32'd1);
    chk("tc_cpc", bus.CorrectPCE, 32'h240);
    tick();
    idle();
    look("tc", 32'h140, 1'b1, 32'h240);

    // Miss, not taken: no write.
    ex(BGE, 32'h80, 1'b0, 32'h100, 1'b0, 32'h84);
    chk("mn_mis", 32'(bus.MispredictE), 32'd0);
    chk("mn_cpc", bus.CorrectPCE, 32'h84);
    tick();
    idle();
    look("mn", 32'h80, 1'b0, 32'h84);
    cnt("mn", 12, 7);

    // Stall three cycles, then release.
    bus.StallE = 1'b1;
    ex(BEQ, 32'h140, 1'b1, 32'h300, 1'b1, 32'h240);
    for (int i = 0; i < 3; i++) begin
      chk("st_mis", 32'(bus.MispredictE), 32'd1);
      tick();
    end
    look("st_hold", 32'h140, 1'b1, 32'h240);
    cnt("st_hold", 12, 7);
    bus.StallE = 1'b0;
    #1;
    look("st_same", 32'h140, 1'b1, 32'h240);
    tick();
    idle();
    look("st_post", 32'h140, 1'b1, 32'h300);
    cnt("st_post", 13, 8);

    // Stats saturate at all-ones.
    for (int i = 0; i < 4; i++) begin
      ex(BEQ, 32'h80, 1'b0, 32'h100, 1'b1, 32'h100);
      tick();
    end
    idle();
    cnt("sat", 15, 12);

    // Asynchronous reset between edges.
    ex(BEQ, 32'h140, 1'b1, 32'h400, 1'b1, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    cnt("arst", 0, 0);
    chk("arst_mis", 32'(bus.MispredictE), 32'd0);
    look("arst", 32'h140, 1'b0, 32'h144);
    tick();
    look("arst_edge", 32'h140, 1'b0, 32'h144);
    idle();
    rst_n = 1'b1;
    tick();
    look("arst_rel", 32'h140, 1'b0, 32'h144);
    cnt("arst_rel", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
